// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-outstanding data memory for the pipeline MEM stage
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic              wr_q;
  logic [15:0]       din_q;
  logic [15:0]       mem [2**ADDR_W];
  logic              accept;
  logic              fire;
  logic              op_wr;
  logic [ADDR_W-1:0] op_idx;
  logic [15:0]       op_din;
  logic              unused_addr;
  assign busy        = state == WAIT;
  assign unused_addr = ^address;
  // fire marks the edge entering the response cycle; with unit latency the request itself is the operand
  always_comb begin
    accept = enable && !rst && !busy;
    fire   = (LATENCY == 1) ? accept : (!rst && state == WAIT && cnt == 4'd1);
    op_wr  = (LATENCY == 1) ? wr : wr_q;
    op_idx = (LATENCY == 1) ? address[ADDR_W:1] : idx_q;
    op_din = (LATENCY == 1) ? data_in : din_q;
  end
  // request capture at acceptance; later input changes have no effect
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= address[ADDR_W:1];
      wr_q  <= wr;
      din_q <= data_in;
    end
  end
  // countdown sequencing, response pulse and load result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      data_valid <= 1'b0;
      data_out   <= 16'h0000;
    end else begin
      data_valid <= fire;
      if (fire && !op_wr) data_out <= mem[op_idx];
      if (accept && LATENCY > 1) begin
        state <= WAIT;
        cnt   <= 4'(LATENCY - 1);
      end else if (fire) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  // store commit; contents survive reset
  always_ff @(posedge clk) begin
    if (fire && op_wr) mem[op_idx] <= op_din;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table, directed and random checks of dmem_responder at latency 4 and 1
module tb_dmem_responder;
  typedef struct {
    bit          f;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, en4 = 1'b0, en1 = 1'b0, wr = 1'b0;
  logic [15:0] address = 16'h0, data_in = 16'h0;
  logic [15:0] dout4, dout1;
  logic dv4, dv1, busy4, busy1;
  int vectors = 0, miscompares = 0;
  logic [15:0] m [2][1024];
  bit k [2][1024];
  logic [15:0] last_load [2];
  vec_t tbl [13];
  logic [15:0] q;
  always #5 clk = ~clk;
  dmem_responder #(.ADDR_W(10), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .enable(en4), .wr(wr), .address(address), .data_in(data_in),
    .data_out(dout4), .data_valid(dv4), .busy(busy4));
  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .wr(wr), .address(address), .data_in(data_in),
    .data_out(dout1), .data_valid(dv1), .busy(busy1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  // one request on the chosen responder, checked against the word-array model
  task automatic xact(input bit f, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] r);
    int lat;
    int idx;
    lat = f ? 1 : 4;
    idx = int'(a[10:1]);
    if (f) en1 = 1'b1; else en4 = 1'b1;
    wr = w; address = a; data_in = d;
    step();
    en1 = 1'b0; en4 = 1'b0; wr = ~w; address = 16'($urandom); data_in = 16'($urandom);
    for (int i = 1; i < lat; i++) begin
      chk("busy_wait", 16'(f ? busy1 : busy4), 16'd1);
      chk("valid_early", 16'(f ? dv1 : dv4), 16'd0);
      step();
    end
    chk("busy_resp", 16'(f ? busy1 : busy4), 16'd0);
    chk("valid_resp", 16'(f ? dv1 : dv4), 16'd1);
    r = f ? dout1 : dout4;
    if (w) begin
      chk("store_hold", r, last_load[f]);
      m[f][idx] = d;
      k[f][idx] = 1'b1;
    end else begin
      if (k[f][idx]) chk("load_data", r, m[f][idx]);
      last_load[f] = r;
    end
  endtask
  initial begin
    tbl = '{
      '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000},
      '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF},
      '{1'b0, 1'b1, 16'h0100, 16'h1111, 16'h0000},
      '{1'b0, 1'b1, 16'h0102, 16'h2222, 16'h0000},
      '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h1111},
      '{1'b0, 1'b0, 16'h0102, 16'h0000, 16'h2222},
      '{1'b0, 1'b1, 16'h0041, 16'h0011, 16'h0000},
      '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0011},
      '{1'b0, 1'b0, 16'h0840, 16'h0000, 16'h0011},
      '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000},
      '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF},
      '{1'b1, 1'b1, 16'h0041, 16'h0011, 16'h0000},
      '{1'b1, 1'b0, 16'h0840, 16'h0000, 16'h0011}
    };
    last_load[0] = 16'h0;
    last_load[1] = 16'h0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_busy4", 16'(busy4), 16'd0);
      chk("rst_valid4", 16'(dv4), 16'd0);
      chk("rst_dout4", dout4, 16'h0000);
      chk("rst_busy1", 16'(busy1), 16'd0);
      chk("rst_valid1", 16'(dv1), 16'd0);
      chk("rst_dout1", dout1, 16'h0000);
      step();
    end
    foreach (tbl[i]) begin
      xact(tbl[i].f, tbl[i].w, tbl[i].a, tbl[i].d, q);
      if (!tbl[i].w) chk("table_load", q, tbl[i].exp);
    end
    en4 = 1'b1; wr = 1'b1; address = 16'h0020; data_in = 16'h1234;
    step();
    en4 = 1'b0;
    step();
    en4 = 1'b1; wr = 1'b0; address = 16'h0030;
    step();
    en4 = 1'b0;
    chk("ign_busy", 16'(busy4), 16'd1);
    step();
    chk("ign_valid", 16'(dv4), 16'd1);
    chk("ign_busy_resp", 16'(busy4), 16'd0);
    chk("ign_hold", dout4, last_load[0]);
    m[0][16] = 16'h1234;
    k[0][16] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ign_no_resp", 16'(dv4), 16'd0);
      chk("ign_idle", 16'(busy4), 16'd0);
    end
    xact(1'b0, 1'b0, 16'h0020, 16'h0, q);
    chk("ign_load", q, 16'h1234);
    xact(1'b0, 1'b1, 16'h0040, 16'h5555, q);
    en4 = 1'b1; wr = 1'b1; address = 16'h0040; data_in = 16'hAAAA;
    step();
    en4 = 1'b0;
    step();
    rst = 1'b1; en1 = 1'b1; wr = 1'b1; address = 16'h0040; data_in = 16'h9999;
    step();
    rst = 1'b0; en1 = 1'b0;
    last_load[0] = 16'h0;
    last_load[1] = 16'h0;
    chk("mid_rst_busy", 16'(busy4), 16'd0);
    chk("mid_rst_valid", 16'(dv4), 16'd0);
    chk("rst_en_valid1", 16'(dv1), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_no_resp", 16'(dv4), 16'd0);
      chk("rst_en_no_resp1", 16'(dv1), 16'd0);
    end
    xact(1'b0, 1'b0, 16'h0040, 16'h0, q);
    chk("mid_rst_load", q, 16'h5555);
    xact(1'b1, 1'b0, 16'h0040, 16'h0, q);
    chk("rst_en_load1", q, 16'h0011);
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      bit f;
      f = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      a[10:1] = 10'($urandom_range(0, 15));
      xact(f, 1'($urandom_range(0, 1)), a, 16'($urandom), q);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step();
        chk("gap_valid4", 16'(dv4), 16'd0);
        chk("gap_valid1", 16'(dv1), 16'd0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
